// File: rtl/rule_match_engine.sv
// rule_match_engine: rule table with a LANES-wide range-match scan, reporting the lowest matching rule.
// Defining RULE_HIT_COUNT_EN adds per-slot 32-bit saturating hit counters readable through count_rd_idx.
module rule_match_engine #(
    parameter int IP_W      = 32,
    parameter int PORT_W    = 16,
    parameter int PROTO_W   = 8,
    parameter int NUM_RULES = 16,
    parameter int LANES     = 4,
    localparam int PKT_W    = 2*IP_W + 2*PORT_W + PROTO_W,
    localparam int IDX_W    = $clog2(NUM_RULES)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rule_wr_en,
    input  logic [IDX_W-1:0] rule_wr_idx,
    input  logic [PKT_W-1:0] rule_wr_start,
    input  logic [PKT_W-1:0] rule_wr_last,
    input  logic             rule_clr,
    input  logic             pkt_valid_in,
    output logic             pkt_ready_out,
    input  logic [PKT_W-1:0] pkt_in,
    output logic             match_valid_out,
    input  logic             match_ready_in,
    output logic             match_hit_out,
    output logic [IDX_W-1:0] match_idx_out,
    input  logic [IDX_W-1:0] count_rd_idx,
    output logic [31:0]      count_rd_data_out
);
    localparam int BEATS = NUM_RULES / LANES;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;
    localparam int O_DP  = PROTO_W;
    localparam int O_DI  = O_DP + PORT_W;
    localparam int O_SP  = O_DI + IP_W;
    localparam int O_SI  = O_SP + PORT_W;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, nxt;

    logic [PKT_W-1:0]     rs [NUM_RULES];
    logic [PKT_W-1:0]     rl [NUM_RULES];
    logic [NUM_RULES-1:0] vld;
    logic [PKT_W-1:0]     pkt_q;
    logic [BW-1:0]        beat, lb_q;
    logic [LANES-1:0]     lane_hit, lh_q;
    logic                 lv_q, hit_q;
    logic [IDX_W-1:0]     idx_q, idx_calc;
    logic [LW-1:0]        lane;
    logic                 accept, found, miss_all;

    function automatic logic rule_hit(input logic [PKT_W-1:0] s, input logic [PKT_W-1:0] l,
                                      input logic [PKT_W-1:0] p);
        return s[O_SI +: IP_W]    <= p[O_SI +: IP_W]    && p[O_SI +: IP_W]    <= l[O_SI +: IP_W]
            && s[O_SP +: PORT_W]  <= p[O_SP +: PORT_W]  && p[O_SP +: PORT_W]  <= l[O_SP +: PORT_W]
            && s[O_DI +: IP_W]    <= p[O_DI +: IP_W]    && p[O_DI +: IP_W]    <= l[O_DI +: IP_W]
            && s[O_DP +: PORT_W]  <= p[O_DP +: PORT_W]  && p[O_DP +: PORT_W]  <= l[O_DP +: PORT_W]
            && s[0 +: PROTO_W]    <= p[0 +: PROTO_W]    && p[0 +: PROTO_W]    <= l[0 +: PROTO_W];
    endfunction

    // Lane compares are registered before the decision so wide (IPv6) compares get a full cycle.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IDX_W-1:0] slot;
        assign slot        = IDX_W'(beat) * IDX_W'(LANES) + IDX_W'(k);
        assign lane_hit[k] = vld[slot] && rule_hit(rs[slot], rl[slot], pkt_q);
    end

    always_comb begin
        lane = '0;
        for (int i = LANES - 1; i >= 0; i--) if (lh_q[i]) lane = LW'(i);
    end

    assign idx_calc = IDX_W'(lb_q) * IDX_W'(LANES) + IDX_W'(lane);
    assign accept   = state == IDLE && pkt_valid_in;
    assign found    = state == SCAN && lv_q && |lh_q;
    assign miss_all = state == SCAN && lv_q && !(|lh_q) && lb_q == BW'(BEATS - 1);

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        nxt = accept ? SCAN
            : (found || miss_all) ? DONE
            : (state == DONE && match_ready_in) ? IDLE : state;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld   <= '0;
            beat  <= '0;
            lv_q  <= 1'b0;
            hit_q <= 1'b0;
            idx_q <= '0;
        end else begin
            if (rule_clr) vld <= '0;
            if (rule_wr_en) vld[rule_wr_idx] <= 1'b1;
            if (accept) beat <= '0;
            else if (state == SCAN && beat != BW'(BEATS - 1)) beat <= beat + 1'b1;
            lv_q <= state == SCAN;
            if (found) begin
                hit_q <= 1'b1;
                idx_q <= idx_calc;
            end else if (miss_all) begin
                hit_q <= 1'b0;
                idx_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rule_wr_en) begin
            rs[rule_wr_idx] <= rule_wr_start;
            rl[rule_wr_idx] <= rule_wr_last;
        end
        if (accept) pkt_q <= pkt_in;
        lh_q <= lane_hit;
        lb_q <= beat;
    end

    assign pkt_ready_out   = state == IDLE && !rst_in;
    assign match_valid_out = state == DONE && !rst_in;
    assign match_hit_out   = hit_q && !rst_in;
    assign match_idx_out   = rst_in ? '0 : idx_q;

`ifdef RULE_HIT_COUNT_EN
    logic [31:0] cnt [NUM_RULES];
    logic [31:0] rd_q;

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_RULES; i++) begin
            if (rst_in || rule_clr || (rule_wr_en && rule_wr_idx == IDX_W'(i))) cnt[i] <= '0;
            else if (found && idx_calc == IDX_W'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 32'd1;
        end
        rd_q <= rst_in ? '0 : cnt[count_rd_idx];
    end

    assign count_rd_data_out = rd_q;
`else
    logic unused_rd;
    assign unused_rd         = ^count_rd_idx;
    assign count_rd_data_out = '0;
`endif
endmodule

// File: tb/tb_rule_match_engine.sv
// tb_rule_match_engine: directed checks of match priority, latency, hold, clear/write ordering and reset.
module tb_rule_match_engine;
    localparam int PKT_W = 104;
    localparam int IDX_W = 4;
    localparam logic [PKT_W-1:0] FULL = '1;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             rule_wr_en = 1'b0;
    logic [IDX_W-1:0] rule_wr_idx = '0;
    logic [PKT_W-1:0] rule_wr_start = '0;
    logic [PKT_W-1:0] rule_wr_last = '0;
    logic             rule_clr = 1'b0;
    logic             pkt_valid_in = 1'b0;
    logic             pkt_ready_out;
    logic [PKT_W-1:0] pkt_in = '0;
    logic             match_valid_out;
    logic             match_ready_in = 1'b0;
    logic             match_hit_out;
    logic [IDX_W-1:0] match_idx_out;
    logic [IDX_W-1:0] count_rd_idx = '0;
    logic [31:0]      count_rd_data_out;

    int checks = 0;
    int failures = 0;

    rule_match_engine dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .rule_wr_en(rule_wr_en), .rule_wr_idx(rule_wr_idx),
        .rule_wr_start(rule_wr_start), .rule_wr_last(rule_wr_last), .rule_clr(rule_clr),
        .pkt_valid_in(pkt_valid_in), .pkt_ready_out(pkt_ready_out), .pkt_in(pkt_in),
        .match_valid_out(match_valid_out), .match_ready_in(match_ready_in),
        .match_hit_out(match_hit_out), .match_idx_out(match_idx_out),
        .count_rd_idx(count_rd_idx), .count_rd_data_out(count_rd_data_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [PKT_W-1:0] pk(input logic [31:0] si, input logic [15:0] sp,
                                            input logic [31:0] di, input logic [15:0] dp,
                                            input logic [7:0] pr);
        return {si, sp, di, dp, pr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [PKT_W-1:0] s, input logic [PKT_W-1:0] l,
                      input logic clr);
        @(negedge clk_in);
        rule_wr_en = 1'b1;
        rule_wr_idx = IDX_W'(idx);
        rule_wr_start = s;
        rule_wr_last = l;
        rule_clr = clr;
        @(negedge clk_in);
        rule_wr_en = 1'b0;
        rule_clr = 1'b0;
    endtask

    task automatic clr_all();
        @(negedge clk_in);
        rule_clr = 1'b1;
        @(negedge clk_in);
        rule_clr = 1'b0;
    endtask

    // Returns with the result on the outputs, sampled after the latency edge.
    task automatic issue(input logic [PKT_W-1:0] p, input string tag, output int lat);
        @(negedge clk_in);
        chk({tag, " ready"}, 32'(pkt_ready_out), 32'd1);
        pkt_valid_in = 1'b1;
        pkt_in = p;
        @(negedge clk_in);
        pkt_valid_in = 1'b0;
        lat = 0;
        while (!match_valid_out && lat < 20) begin
            @(negedge clk_in);
            lat++;
        end
    endtask

    task automatic send(input logic [PKT_W-1:0] p, input logic eh, input int ei, input int el,
                        input string tag);
        int lat;
        issue(p, tag, lat);
        chk({tag, " lat"}, 32'(lat), 32'(el));
        chk({tag, " hit"}, 32'(match_hit_out), 32'(eh));
        chk({tag, " idx"}, 32'(match_idx_out), 32'(ei));
        match_ready_in = 1'b1;
        @(negedge clk_in);
        chk({tag, " drop"}, {30'd0, match_valid_out, pkt_ready_out}, 32'd1);
        match_ready_in = 1'b0;
    endtask

    logic [PKT_W-1:0] p7, s5, l5;
    int lat;
    logic seen;

    initial begin
        p7 = pk(32'h0A000007, 16'd1234, 32'hC0A80001, 16'd80, 8'd6);
        s5 = pk(32'h0A000000, 16'h0, 32'h0, 16'h0, 8'h0);
        l5 = pk(32'h0A0000FF, 16'hFFFF, 32'hFFFFFFFF, 16'hFFFF, 8'hFF);

        @(negedge clk_in);
        chk("rst ready", 32'(pkt_ready_out), 32'd0);
        chk("rst valid", 32'(match_valid_out), 32'd0);
        chk("rst hit", 32'(match_hit_out), 32'd0);
        chk("rst idx", 32'(match_idx_out), 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("post rst ready", 32'(pkt_ready_out), 32'd1);

        wr(5, s5, l5, 1'b0);
        send(p7, 1'b1, 5, 3, "slot5");
        send(pk(32'h0A0000FF, 16'd1, 32'd2, 16'd3, 8'd4), 1'b1, 5, 3, "slot5 upper");
        send(pk(32'h0A000100, 16'd1, 32'd2, 16'd3, 8'd4), 1'b0, 0, 5, "slot5 above");
        send(pk(32'h09FFFFFF, 16'd1, 32'd2, 16'd3, 8'd4), 1'b0, 0, 5, "slot5 below");
`ifndef RULE_HIT_COUNT_EN
        chk("count tied", count_rd_data_out, 32'd0);
`endif

        // Hold: result stays put for 10 cycles, including across a rewrite of slot 5.
        issue(p7, "hold", lat);
        chk("hold lat", 32'(lat), 32'd3);
        for (int i = 0; i < 10; i++) begin
            rule_wr_en = (i == 3);
            rule_wr_idx = 4'd5;
            rule_wr_start = pk(32'h0B000000, 16'h0, 32'h0, 16'h0, 8'h0);
            rule_wr_last = pk(32'h0B0000FF, 16'hFFFF, 32'hFFFFFFFF, 16'hFFFF, 8'hFF);
            @(negedge clk_in);
            chk("hold valid", 32'(match_valid_out), 32'd1);
            chk("hold hit", 32'(match_hit_out), 32'd1);
            chk("hold idx", 32'(match_idx_out), 32'd5);
            chk("hold ready", 32'(pkt_ready_out), 32'd0);
        end
        rule_wr_en = 1'b0;
        match_ready_in = 1'b1;
        @(negedge clk_in);
        chk("hold release valid", 32'(match_valid_out), 32'd0);
        chk("hold release ready", 32'(pkt_ready_out), 32'd1);
        match_ready_in = 1'b0;
        send(p7, 1'b0, 0, 5, "rewritten slot5");

        clr_all();
        wr(2, '0, FULL, 1'b0);
        wr(3, '0, FULL, 1'b0);
        send(p7, 1'b1, 2, 2, "slots 2,3");

        clr_all();
        wr(3, '0, FULL, 1'b0);
        wr(9, '0, FULL, 1'b0);
        send(p7, 1'b1, 3, 2, "slots 3,9");

        clr_all();
        wr(3, '0, FULL, 1'b0);
        wr(9, '0, FULL, 1'b1);
        send(p7, 1'b1, 9, 4, "clr+wr");

        clr_all();
        send(p7, 1'b0, 0, 5, "empty");

        wr(0, pk(32'h0, 16'h0, 32'h0, 16'h0, 8'h10), pk('1, '1, '1, '1, 8'h05), 1'b0);
        send(pk(32'd1, 16'd2, 32'd3, 16'd4, 8'h06), 1'b0, 0, 5, "inverted p6");
        send(pk(32'd1, 16'd2, 32'd3, 16'd4, 8'h10), 1'b0, 0, 5, "inverted p16");
        wr(1, pk(32'h0, 16'h0, 32'h0, 16'h0, 8'h06), pk('1, '1, '1, '1, 8'h06), 1'b0);
        send(pk(32'd1, 16'd2, 32'd3, 16'd4, 8'h06), 1'b1, 1, 2, "proto exact");
        send(pk(32'd1, 16'd2, 32'd3, 16'd4, 8'h07), 1'b0, 0, 5, "proto off");

        // Reset while beat 2 is being compared; slot 13 would hit in beat 3.
        clr_all();
        wr(13, '0, FULL, 1'b0);
        @(negedge clk_in);
        pkt_valid_in = 1'b1;
        pkt_in = p7;
        @(negedge clk_in);
        pkt_valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("midscan rst valid", 32'(match_valid_out), 32'd0);
        chk("midscan rst ready", 32'(pkt_ready_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            seen |= match_valid_out;
        end
        chk("midscan no result", 32'(seen), 32'd0);
        send(p7, 1'b0, 0, 5, "after rst");

`ifdef RULE_HIT_COUNT_EN
        wr(1, '0, FULL, 1'b0);
        for (int i = 0; i < 3; i++) send(p7, 1'b1, 1, 2, "cnt hit");
        count_rd_idx = 4'd1;
        @(negedge clk_in);
        chk("cnt three", count_rd_data_out, 32'd3);
        clr_all();
        @(negedge clk_in);
        chk("cnt cleared", count_rd_data_out, 32'd0);
        wr(1, '0, FULL, 1'b0);
        dut.cnt[1] = 32'hFFFFFFFF;
        send(p7, 1'b1, 1, 2, "cnt sat");
        @(negedge clk_in);
        chk("cnt saturated", count_rd_data_out, 32'hFFFFFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rule_match_engine.md
Name: rule_match_engine

Overview:
- Parametrised successor to the fixed-width packet/rule types: a rule table plus a multi-lane range-match engine.
- Stores NUM_RULES rules; each rule is a per-field [start, last] range.
- Accepts one 5-tuple packet at a time and scans the table LANES rules per cycle.
- Reports the lowest-index matching rule. Sits between the packet parser and the action/lookup stage of the classifier.

Parameters:
IP_W, 32, IP address field width (128 for IPv6 builds)
PORT_W, 16, port field width
PROTO_W, 8, protocol field width
NUM_RULES, 16, table depth; must be a multiple of LANES
LANES, 4, rules compared per cycle
(derived) PKT_W = 2*IP_W + 2*PORT_W + PROTO_W; IDX_W = $clog2(NUM_RULES); BEATS = NUM_RULES/LANES

Ports:
clk_in  input  1  single clock
rst_in  input  1  synchronous reset, active high
rule_wr_en  input  1  write rule_wr_start/last into slot rule_wr_idx and set its valid bit
rule_wr_idx  input  IDX_W  slot to write
rule_wr_start  input  PKT_W  packed lower bounds
rule_wr_last  input  PKT_W  packed upper bounds
rule_clr  input  1  invalidate all slots
pkt_valid_in  input  1  packet available
pkt_ready_out  output  1  engine can accept a packet
pkt_in  input  PKT_W  packed packet
match_valid_out  output  1  result available
match_ready_in  input  1  consumer takes result
match_hit_out  output  1  1 = some rule matched
match_idx_out  output  IDX_W  matching rule index (0 on miss)
count_rd_idx  input  IDX_W  hit-counter read index (optional feature)
count_rd_data_out  output  32  hit-counter read data (optional feature)

Behaviour:
- Clocking: one clock; reset is synchronous and active-high, named clk_in / rst_in.
- Packing, MSB to LSB: {src_ip, src_port, dst_ip, dst_port, protocol}.
- Match rule: the rule valid bit is set AND every field satisfies start <= f <= last, unsigned. A rule with start > last in any field never matches.
- FSM states:
  - IDLE: pkt_ready_out=1. On pkt_valid_in & pkt_ready_out, latch pkt_in, beat=0, go to SCAN.
  - SCAN: compare slots beat*LANES .. beat*LANES+LANES-1.
    - Any hit: register hit=1 and the lowest hitting index, go to DONE.
    - No hit and beat==BEATS-1: register hit=0, idx=0, go to DONE.
    - Otherwise beat++.
  - DONE: match_valid_out=1. Result held stable until match_ready_in. Then go to IDLE, drop match_valid_out.
- pkt_ready_out is 0 in SCAN and DONE, so there is exactly one packet in flight.
- Latency: packet accepted on edge E. A hit in beat b gives match_valid_out high b+2 cycles after E. A full miss gives BEATS+1 cycles after E.
- Back-to-back throughput: with match_ready_in tied high, DONE lasts 1 cycle, and IDLE accepts on the following cycle.
- Table writes:
  - Permitted in any state. A write takes effect at the clock edge.
  - A scan beat in the same cycle as a write to a slot being compared uses the pre-write contents.
- rule_clr and rule_wr_en in the same cycle: clear applies first, then the write. Result: only the written slot is valid.
- Writes never disturb an in-flight scan or a result held in DONE.
- Reset:
  - FSM to IDLE; all valid bits cleared (rule data need not reset).
  - pkt_ready_out, match_valid_out, match_hit_out, match_idx_out all 0 while rst_in is high. pkt_ready_out=1 on the first cycle after release.
  - Reset mid-scan or in DONE discards the packet; no result is emitted.

Optional Feature:
- Macro: RULE_HIT_COUNT_EN.
- Defined:
  - Each slot has a 32-bit saturating hit counter (stays at 0xFFFFFFFF), incremented when that slot is the reported match.
  - Cleared on reset, on rule_clr, and on a write to that slot.
  - count_rd_data_out = counter[count_rd_idx], registered, 1-cycle read latency.
  - Read and increment of the same slot in the same cycle returns the pre-increment value.
- Undefined: no counters; count_rd_data_out tied to 0; count_rd_idx ignored.

Test Plan:
- Defaults; write slot 5 = src_ip 10.0.0.0–10.0.0.255, all other fields full range. Send src_ip 10.0.0.7 -> hit=1, idx=5, match_valid_out 3 cycles after accept (beat 1).
- Slots 2 and 3 both match the packet -> idx=2. Slots 3 and 9 both match -> idx=3, reported in beat 0.
- Empty table -> hit=0, idx=0, match_valid_out exactly BEATS+1=5 cycles after accept. Slot with start>last in the protocol field -> never hits.
- Hold match_ready_in=0 for 10 cycles -> result stable, pkt_ready_out=0 throughout. Release -> IDLE next cycle, next packet accepted.
- Assert rst_in during SCAN beat 2 -> no match_valid_out, all slots invalid. The next packet misses even if it matched before reset.
- With RULE_HIT_COUNT_EN: 3 packets hit slot 1 -> count_rd_idx=1 reads 3. After rule_clr it reads 0. Preload the counter at 0xFFFFFFFF -> it stays 0xFFFFFFFF.
